eprisc_sysx_slave: RTL and testbench
====================================

# eprisc_sysx_slave

Responder end of the epRISC sysX peripheral bus: decodes frames driven by the sysX master (bus clock, 2-bit select, 8-bit MOSI) and answers on 8-bit MISO. It sits inside each sysX peripheral and presents frames as single-cycle register read/write strobes to local peripheral logic. It optionally raises the shared bus interrupt line.

## Interface
- SLAVE_ID, 2'd1: select code this slave answers to; select code 0 means the bus is idle.
- SYNC_STAGES, 2: synchronizer depth on bus clock, select and MOSI.
- iClock  in  1  local system clock; all state is clocked on its rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iBusClock  in  1  sysX bus clock from the master; asynchronous to iClock.
- iBusSelect  in  2  slave select code.
- iBusMOSI  in  8  master-to-slave byte.
- oBusMISO  out  8  slave-to-master byte.
- oBusMISOEnable  out  1  high while this slave drives MISO; top level tri-states MISO on it.
- oBusInterrupt  out  1  active-high interrupt request to the master.
- oRegAddress  out  7  register address of the current frame.
- oRegWriteData  out  32  assembled write word.
- oRegWrite  out  1  one-cycle write strobe.
- oRegRead  out  1  one-cycle read strobe.
- iRegReadData  in  32  read word; must be valid the cycle after oRegRead.
- iIrqRequest  in  1  level interrupt request from the peripheral.

## Operation
- Inputs are synchronized (SYNC_STAGES flops); rising and falling bus-clock edges are detected on the synchronized copy.
- Frame = select held at SLAVE_ID. The slave samples MOSI on each detected rising edge and updates MISO on each detected falling edge.
- Byte 0 is the command byte: bit 7 = write (1) or read (0); bits 6:0 = address.
- Write frame: bytes 1..4 are data, MSB first. After byte 4 is sampled, oRegWrite pulses one cycle with oRegAddress and oRegWriteData valid.
- Read frame: oRegRead pulses on the cycle after the command byte is sampled. iRegReadData is captured into a 32-bit shift register on the following cycle. Bytes 1..4 are driven MSB first, each on the falling edge preceding the rising edge of its byte slot.
- Bytes after byte 4 are ignored. In that phase, MISO drives 8'h00 with enable high for read frames and enable low for write frames.
- States:
  - IDLE -> CMD when select == SLAVE_ID.
  - CMD -> WDATA (write) or RFETCH (read).
  - RFETCH -> RDATA after 2 cycles.
  - WDATA / RDATA -> DONE after 4 bytes.
  - Any state -> IDLE whenever select != SLAVE_ID.
- Select dropping mid-frame aborts the frame: no strobe is issued, the byte counter clears, and MISO enable drops on the next cycle.
- oBusMISOEnable is high only in RFETCH, RDATA and DONE of read frames.
- The byte counter is 3 bits and saturates at 5; it never wraps.

## Timing
- Bus clock high and low phases must each be at least 4 iClock periods; bus inputs are stable for at least SYNC_STAGES+1 cycles around the bus-clock rising edge.
- Edge detect latency: SYNC_STAGES+1 cycles after the pin transitions.
- Write strobe: 1 cycle after the byte-4 rising edge is detected.
- Read: strobe 1 cycle after the command edge is detected; capture 1 cycle later; byte 1 driven on the next falling edge (at least 4 cycles later).
- Reset values: oBusMISO 0, oBusMISOEnable 0, oBusInterrupt 0, oRegAddress 0, oRegWriteData 0, oRegWrite 0, oRegRead 0, state IDLE.
- Reset asserted mid-frame returns the block to IDLE immediately; the frame is lost and the master must re-issue it.

## Configuration
- SYSX_SLAVE_IRQ_EN defined:
  - iIrqRequest high sets a pending flop; oBusInterrupt = pending.
  - A write frame to address 7'h7F clears pending and is not forwarded (no oRegWrite).
  - A read of 7'h7F returns {31'b0, pending} without an oRegRead strobe.
  - If iIrqRequest and the clear arrive in the same cycle, set wins.
- SYSX_SLAVE_IRQ_EN undefined: oBusInterrupt is tied 0, and 7'h7F is an ordinary register address.

## Structure
- Shared package eprisc_sysx_pkg holds:
  - state enum;
  - command field positions (write bit 7, address 6:0);
  - IRQ_ACK_ADDR = 7'h7F;
  - FRAME_BYTES = 5.
- Sub-module eprisc_sysx_sync: parameterized-width synchronizer with rising/falling edge outputs for the bus clock.

## Test plan
- Write frame, select=1, bytes 8'h85, DE, AD, BE, EF -> one oRegWrite pulse, oRegAddress=7'h05, oRegWriteData=32'hDEADBEEF.
- Read frame 8'h0A with iRegReadData=32'h12345678 -> one oRegRead pulse, address 7'h0A, MISO bytes 12,34,56,78, enable low after select drops.
- Select=2 while SLAVE_ID=1, full write frame -> no strobes, oBusMISOEnable stays 0.
- Write frame aborted after byte 2 (select to 0), then a full write of 32'h00000001 -> exactly one strobe, with data 32'h00000001.
- SYSX_SLAVE_IRQ_EN: pulse iIrqRequest -> oBusInterrupt=1; read 7'h7F returns 32'h1; write 7'h7F -> oBusInterrupt=0, no oRegWrite.
- iReset low during RDATA -> all outputs at reset values within the same cycle; the next frame decodes normally.

Source files
------------

// File: rtl/eprisc_sysx_pkg.sv
// Shared definitions for the epRISC sysX slave: frame states, command byte
// layout, the interrupt-acknowledge register address and the frame length.
package eprisc_sysx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      WDATA  = 3'd2,
      RFETCH = 3'd3,
      RDATA  = 3'd4,
      DONE   = 3'd5
   } sysxState_t;

   localparam int         CMD_WRITE_BIT = 7;
   localparam int         CMD_ADDR_MSB  = 6;
   localparam int         CMD_ADDR_LSB  = 0;
   localparam logic [6:0] IRQ_ACK_ADDR  = 7'h7F;
   localparam logic [2:0] FRAME_BYTES   = 3'd5;

endpackage

// File: rtl/eprisc_sysx_sync.sv
// Multi-stage synchronizer for the sysX bus pins. Bit 0 of the vector is the
// bus clock; registered rise/fall pulses are produced from its synchronized copy.
module eprisc_sysx_sync #(
   parameter int WIDTH  = 11,
   parameter int STAGES = 2
) (
   input  logic             iClock,
   input  logic             iReset,
   input  logic [WIDTH-1:0] iAsync,
   output logic [WIDTH-1:0] oSync,
   output logic             oRise,
   output logic             oFall
);

   logic [WIDTH-1:0] chain [STAGES];
   logic             prevEdge;

   assign oSync = chain[STAGES-1];

   // Synchronizer chain plus one-cycle edge pulses on the bus clock bit.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
         prevEdge <= 1'b0;
         oRise    <= 1'b0;
         oFall    <= 1'b0;
      end else begin
         chain[0] <= iAsync;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         prevEdge <= chain[STAGES-1][0];
         oRise    <= chain[STAGES-1][0] & ~prevEdge;
         oFall    <= ~chain[STAGES-1][0] & prevEdge;
      end
   end

endmodule

// File: rtl/eprisc_sysx_slave.sv
// epRISC sysX bus slave: turns master frames into single-cycle register
// read/write strobes for the local peripheral and shifts read data out on MISO.
// Optional feature macro: SYSX_SLAVE_IRQ_EN (interrupt pending flop, with
// address 7'h7F used as the pending read/acknowledge register).
//
// state  | meaning
// IDLE   | not selected, waiting for select == SLAVE_ID
// CMD    | selected, waiting for the command byte
// WDATA  | write frame, collecting data bytes 1..4
// RFETCH | read frame, strobe issued, capturing read data
// RDATA  | read frame, shifting bytes 1..4 out on MISO
// DONE   | frame complete, further bytes ignored
module eprisc_sysx_slave
   import eprisc_sysx_pkg::*;
#(
   parameter logic [1:0] SLAVE_ID    = 2'd1,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iBusClock,
   input  logic [1:0]  iBusSelect,
   input  logic [7:0]  iBusMOSI,
   output logic [7:0]  oBusMISO,
   output logic        oBusMISOEnable,
   output logic        oBusInterrupt,
   output logic [6:0]  oRegAddress,
   output logic [31:0] oRegWriteData,
   output logic        oRegWrite,
   output logic        oRegRead,
   input  logic [31:0] iRegReadData,
   input  logic        iIrqRequest
);

   localparam int SYNC_WIDTH = 11;

   sysxState_t            state, stateNext;
   logic [SYNC_WIDTH-1:0] busSync;
   logic                  busRise, busFall, selMatch, lastByte;
   logic [7:0]            mosiSync;
   logic [2:0]            byteCount;
   logic                  isWrite, fetchPhase;
   logic                  irqPending, ackHit, ackCmd;
   logic                  writeStrobeNext, readStrobeNext;
   logic [31:0]           shiftReg;

   eprisc_sysx_sync #(
      .WIDTH  (SYNC_WIDTH),
      .STAGES (SYNC_STAGES)
   ) uSync (
      .iClock (iClock),
      .iReset (iReset),
      .iAsync ({iBusSelect, iBusMOSI, iBusClock}),
      .oSync  (busSync),
      .oRise  (busRise),
      .oFall  (busFall)
   );

   assign selMatch = (busSync[10:9] == SLAVE_ID);
   assign mosiSync = busSync[8:1];
   assign lastByte = busRise && (byteCount == FRAME_BYTES - 3'd1);

   assign oBusMISOEnable = (state == RFETCH) || (state == RDATA) ||
                           ((state == DONE) && !isWrite);

`ifdef SYSX_SLAVE_IRQ_EN
   logic irqClear;

   assign ackHit        = (oRegAddress == IRQ_ACK_ADDR);
   assign ackCmd        = (mosiSync[CMD_ADDR_MSB:CMD_ADDR_LSB] == IRQ_ACK_ADDR);
   assign irqClear      = (state == WDATA) && lastByte && selMatch && ackHit;
   assign oBusInterrupt = irqPending;

   // Pending interrupt: a new request beats a simultaneous acknowledge.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset)          irqPending <= 1'b0;
      else if (iIrqRequest) irqPending <= 1'b1;
      else if (irqClear)    irqPending <= 1'b0;
   end
`else
   logic unusedIrqRequest;

   assign unusedIrqRequest = iIrqRequest;
   assign ackHit           = 1'b0;
   assign ackCmd           = 1'b0;
   assign irqPending       = 1'b0;
   assign oBusInterrupt    = 1'b0;
`endif

   // State register.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) state <= IDLE;
      else         state <= stateNext;
   end

   // Next-state and strobe decode; losing select aborts from any state.
   always_comb begin
      stateNext       = state;
      writeStrobeNext = 1'b0;
      readStrobeNext  = 1'b0;
      case (state)
         IDLE:   if (selMatch) stateNext = CMD;
         CMD:    if (busRise) begin
                    if (mosiSync[CMD_WRITE_BIT]) begin
                       stateNext = WDATA;
                    end else begin
                       stateNext      = RFETCH;
                       readStrobeNext = !ackCmd;
                    end
                 end
         WDATA:  if (lastByte) begin
                    stateNext       = DONE;
                    writeStrobeNext = !ackHit;
                 end
         RFETCH: if (fetchPhase) stateNext = RDATA;
         RDATA:  if (lastByte) stateNext = DONE;
         DONE:   stateNext = DONE;
         default: stateNext = IDLE;
      endcase
      if (!selMatch) begin
         stateNext       = IDLE;
         writeStrobeNext = 1'b0;
         readStrobeNext  = 1'b0;
      end
   end

   // Frame datapath: command decode, byte counter, write assembly, read shifter.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         oBusMISO      <= 8'h00;
         oRegAddress   <= 7'h00;
         oRegWriteData <= 32'h0;
         oRegWrite     <= 1'b0;
         oRegRead      <= 1'b0;
         byteCount     <= 3'd0;
         isWrite       <= 1'b0;
         fetchPhase    <= 1'b0;
         shiftReg      <= 32'h0;
      end else begin
         oRegWrite <= writeStrobeNext;
         oRegRead  <= readStrobeNext;
         if (!selMatch) begin
            byteCount  <= 3'd0;
            fetchPhase <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  byteCount  <= 3'd0;
                  fetchPhase <= 1'b0;
                  oBusMISO   <= 8'h00;
               end
               CMD: if (busRise) begin
                  oRegAddress <= mosiSync[CMD_ADDR_MSB:CMD_ADDR_LSB];
                  isWrite     <= mosiSync[CMD_WRITE_BIT];
                  byteCount   <= 3'd1;
               end
               WDATA: if (busRise) begin
                  oRegWriteData <= {oRegWriteData[23:0], mosiSync};
                  byteCount     <= byteCount + 3'd1;
               end
               RFETCH: begin
                  fetchPhase <= 1'b1;
                  if (fetchPhase) shiftReg <= ackHit ? {31'b0, irqPending} : iRegReadData;
               end
               RDATA: begin
                  if (busFall) begin
                     oBusMISO <= shiftReg[31:24];
                     shiftReg <= {shiftReg[23:0], 8'h00};
                  end
                  if (busRise) byteCount <= byteCount + 3'd1;
               end
               DONE: begin
                  if (busFall) oBusMISO <= 8'h00;
                  if (busRise && (byteCount != FRAME_BYTES)) byteCount <= byteCount + 3'd1;
               end
               default: byteCount <= 3'd0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eprisc_sysx_slave.sv
// Directed bench for eprisc_sysx_slave: a sysX master task drives frames,
// a monitor records strobes and a responder answers reads one cycle late.
module tb_eprisc_sysx_slave;

   logic        iClock = 1'b0;
   logic        iReset = 1'b0;
   logic        iBusClock = 1'b0;
   logic [1:0]  iBusSelect = 2'd0;
   logic [7:0]  iBusMOSI = 8'h00;
   logic [7:0]  oBusMISO;
   logic        oBusMISOEnable;
   logic        oBusInterrupt;
   logic [6:0]  oRegAddress;
   logic [31:0] oRegWriteData;
   logic        oRegWrite;
   logic        oRegRead;
   logic [31:0] iRegReadData = 32'h0;
   logic        iIrqRequest = 1'b0;

   int          nCompared = 0;
   int          nMismatched = 0;
   int          wrCount = 0;
   int          rdCount = 0;
   int          enHigh = 0;
   logic [6:0]  lastWrAddr = 7'h00;
   logic [31:0] lastWrData = 32'h0;
   logic [6:0]  lastRdAddr = 7'h00;
   logic [31:0] readValue = 32'h0;
   logic [7:0]  txBytes [8];
   logic [7:0]  rxBytes [8];
   logic        rxEn [8];
   int          wrBase, rdBase;

   eprisc_sysx_slave #(.SLAVE_ID(2'd1), .SYNC_STAGES(2)) dut (
      .iClock         (iClock),
      .iReset         (iReset),
      .iBusClock      (iBusClock),
      .iBusSelect     (iBusSelect),
      .iBusMOSI       (iBusMOSI),
      .oBusMISO       (oBusMISO),
      .oBusMISOEnable (oBusMISOEnable),
      .oBusInterrupt  (oBusInterrupt),
      .oRegAddress    (oRegAddress),
      .oRegWriteData  (oRegWriteData),
      .oRegWrite      (oRegWrite),
      .oRegRead       (oRegRead),
      .iRegReadData   (iRegReadData),
      .iIrqRequest    (iIrqRequest)
   );

   always #5 iClock = ~iClock;

   // Read data is only valid in the cycle after the strobe.
   always @(posedge iClock) iRegReadData <= oRegRead ? readValue : 32'hBAD0_0BAD;

   always @(negedge iClock) begin
      if (oRegWrite) begin
         wrCount++;
         lastWrAddr = oRegAddress;
         lastWrData = oRegWriteData;
      end
      if (oRegRead) begin
         rdCount++;
         lastRdAddr = oRegAddress;
      end
      if (oBusMISOEnable) enHigh++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic runFrame(input logic [1:0] sel, input int nBytes, input bit leaveOpen);
      iBusSelect = sel;
      iBusClock  = 1'b0;
      repeat (4) @(negedge iClock);
      for (int i = 0; i < nBytes; i++) begin
         iBusMOSI = txBytes[i];
         repeat (8) @(negedge iClock);
         rxBytes[i] = oBusMISO;
         rxEn[i]    = oBusMISOEnable;
         iBusClock  = 1'b1;
         repeat (8) @(negedge iClock);
         iBusClock  = 1'b0;
      end
      if (!leaveOpen) begin
         iBusSelect = 2'd0;
         repeat (8) @(negedge iClock);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, " miso"},   {24'h0, oBusMISO},      32'h0);
      check({tag, " en"},     {31'h0, oBusMISOEnable}, 32'h0);
      check({tag, " irq"},    {31'h0, oBusInterrupt},  32'h0);
      check({tag, " addr"},   {25'h0, oRegAddress},    32'h0);
      check({tag, " wdata"},  oRegWriteData,           32'h0);
      check({tag, " wr"},     {31'h0, oRegWrite},      32'h0);
      check({tag, " rd"},     {31'h0, oRegRead},       32'h0);
   endtask

   initial begin
      repeat (3) @(negedge iClock);
      #1;
      checkResetOutputs("reset");
      iReset = 1'b1;
      repeat (4) @(negedge iClock);

      // Plain write frame.
      enHigh = 0;
      txBytes[0] = 8'h85; txBytes[1] = 8'hDE; txBytes[2] = 8'hAD;
      txBytes[3] = 8'hBE; txBytes[4] = 8'hEF;
      runFrame(2'd1, 5, 1'b0);
      check("write count", wrCount, 1);
      check("write addr", {25'h0, lastWrAddr}, 32'h05);
      check("write data", lastWrData, 32'hDEADBEEF);
      check("write en", enHigh, 0);
      check("write no read", rdCount, 0);

      // Read frame with one trailing byte after the data.
      readValue  = 32'h12345678;
      txBytes[0] = 8'h0A;
      for (int i = 1; i < 6; i++) txBytes[i] = 8'h00;
      runFrame(2'd1, 6, 1'b0);
      check("read count", rdCount, 1);
      check("read addr", {25'h0, lastRdAddr}, 32'h0A);
      check("read cmd en", {31'h0, rxEn[0]}, 32'h0);
      check("read b1", {24'h0, rxBytes[1]}, 32'h12);
      check("read b2", {24'h0, rxBytes[2]}, 32'h34);
      check("read b3", {24'h0, rxBytes[3]}, 32'h56);
      check("read b4", {24'h0, rxBytes[4]}, 32'h78);
      check("read b1 en", {31'h0, rxEn[1]}, 32'h1);
      check("read extra", {24'h0, rxBytes[5]}, 32'h00);
      check("read extra en", {31'h0, rxEn[5]}, 32'h1);
      check("read en after", {31'h0, oBusMISOEnable}, 32'h0);
      check("read no write", wrCount, 1);

      // Other slave selected.
      enHigh = 0;
      txBytes[0] = 8'h85; txBytes[1] = 8'h11; txBytes[2] = 8'h22;
      txBytes[3] = 8'h33; txBytes[4] = 8'h44;
      runFrame(2'd2, 5, 1'b0);
      check("other sel write", wrCount, 1);
      check("other sel read", rdCount, 1);
      check("other sel en", enHigh, 0);

      // Aborted write followed by a complete one.
      txBytes[0] = 8'h83; txBytes[1] = 8'hAA; txBytes[2] = 8'hBB;
      runFrame(2'd1, 3, 1'b0);
      check("abort no strobe", wrCount, 1);
      txBytes[0] = 8'h83; txBytes[1] = 8'h00; txBytes[2] = 8'h00;
      txBytes[3] = 8'h00; txBytes[4] = 8'h01;
      runFrame(2'd1, 5, 1'b0);
      check("after abort count", wrCount, 2);
      check("after abort addr", {25'h0, lastWrAddr}, 32'h03);
      check("after abort data", lastWrData, 32'h00000001);

      // Interrupt request and register 7'h7F.
      wrBase = wrCount;
      rdBase = rdCount;
      iIrqRequest = 1'b1;
      @(negedge iClock);
      iIrqRequest = 1'b0;
      repeat (2) @(negedge iClock);
`ifdef SYSX_SLAVE_IRQ_EN
      check("irq set", {31'h0, oBusInterrupt}, 32'h1);
      readValue  = 32'hFFFFFFFF;
      txBytes[0] = 8'h7F;
      for (int i = 1; i < 5; i++) txBytes[i] = 8'h00;
      runFrame(2'd1, 5, 1'b0);
      check("irq read no strobe", rdCount, rdBase);
      check("irq read b1", {24'h0, rxBytes[1]}, 32'h00);
      check("irq read b3", {24'h0, rxBytes[3]}, 32'h00);
      check("irq read b4", {24'h0, rxBytes[4]}, 32'h01);
      check("irq still set", {31'h0, oBusInterrupt}, 32'h1);
      txBytes[0] = 8'hFF;
      runFrame(2'd1, 5, 1'b0);
      check("irq ack clear", {31'h0, oBusInterrupt}, 32'h0);
      check("irq ack no write", wrCount, wrBase);
`else
      check("irq tied low", {31'h0, oBusInterrupt}, 32'h0);
      txBytes[0] = 8'hFF; txBytes[1] = 8'h11; txBytes[2] = 8'h22;
      txBytes[3] = 8'h33; txBytes[4] = 8'h44;
      runFrame(2'd1, 5, 1'b0);
      check("7F write count", wrCount, wrBase + 1);
      check("7F write addr", {25'h0, lastWrAddr}, 32'h7F);
      check("7F write data", lastWrData, 32'h11223344);
`endif

      // Reset in the middle of a read's data phase.
      readValue  = 32'h12345678;
      txBytes[0] = 8'h0A; txBytes[1] = 8'h00;
      runFrame(2'd1, 2, 1'b1);
      repeat (6) @(negedge iClock);
      check("pre-reset miso", {24'h0, oBusMISO}, 32'h34);
      iReset = 1'b0;
      #1;
      checkResetOutputs("mid reset");
      iBusSelect = 2'd0;
      repeat (3) @(negedge iClock);
      iReset = 1'b1;
      repeat (4) @(negedge iClock);
      wrBase = wrCount;
      txBytes[0] = 8'h86; txBytes[1] = 8'hCA; txBytes[2] = 8'hFE;
      txBytes[3] = 8'hBA; txBytes[4] = 8'hBE;
      runFrame(2'd1, 5, 1'b0);
      check("post reset count", wrCount, wrBase + 1);
      check("post reset addr", {25'h0, lastWrAddr}, 32'h06);
      check("post reset data", lastWrData, 32'hCAFEBABE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
